// File: rtl/dbus_ram_responder.sv
// dbus_ram_responder: RV32I data-bus RAM responder with sized loads/stores, wait states and fault flag.
// Ports: clk, reset (sync, active-high); dbus_re/dbus_we/dbus_addr/dbus_f3/dbus_wdata request;
// dbus_rdata/dbus_ready/dbus_fault response; mmio_out/mmio_strobe only when DBUS_MMIO_EN is defined.
module dbus_ram_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dbus_re,
  input  logic        dbus_we,
  input  logic [31:0] dbus_addr,
  input  logic [2:0]  dbus_f3,
  input  logic [31:0] dbus_wdata,
  output logic [31:0] dbus_rdata,
  output logic        dbus_ready,
  output logic        dbus_fault
`ifdef DBUS_MMIO_EN
  ,
  output logic [31:0] mmio_out,
  output logic        mmio_strobe
`endif
);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  logic [1:0] state;
  logic [3:0] cnt;
  logic [31:0] addr_q, wdata_q;
  logic [2:0] f3_q;
  logic re_q, we_q;
  logic [31:0] mem [1 << ADDR_WIDTH];
  logic idle, req, enter, op_re, op_we, hit, f3_bad, mis, oor, fault, commit;
  logic [31:0] a, d, word, load, wsh;
  logic [2:0] f3;
  logic [3:0] be;
  logic [ADDR_WIDTH-1:0] idx;
  logic [7:0] byte_v;
  logic [15:0] half_v;
  // While idle the live request is classified so a zero-wait access can finish on its first edge.
  assign idle  = state == IDLE;
  assign req   = dbus_re | dbus_we;
  assign a     = idle ? dbus_addr : addr_q;
  assign d     = idle ? dbus_wdata : wdata_q;
  assign f3    = idle ? dbus_f3 : f3_q;
  assign op_re = idle ? dbus_re : re_q;
  assign op_we = idle ? dbus_we : we_q;
  assign enter = idle ? req && WAIT_STATES == 0 : state == WAIT && cnt == 4'd0;
`ifdef DBUS_MMIO_EN
  assign hit = a == 32'hFFFF_FFF0;
`else
  assign hit = 1'b0;
`endif
  assign f3_bad = op_we ? f3[2] | (f3[1:0] == 2'b11) : (f3 == 3'b011) | (f3[2:1] == 2'b11);
  assign mis    = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
  assign oor    = (a >> (ADDR_WIDTH + 2)) != 32'd0;
  assign fault  = (op_re & op_we) | (hit ? f3 != 3'b010 : f3_bad | mis | oor);
  assign commit = enter & op_we & ~fault & ~hit;
  assign idx    = a[ADDR_WIDTH+1:2];
  assign word   = mem[idx];
  assign byte_v = word[{a[1:0], 3'b000} +: 8];
  assign half_v = word[{a[1], 4'b0000} +: 16];
  // f3[2] selects zero extension; f3[1] marks a full word.
  assign load   = f3[1] ? word : f3[0] ? {{16{~f3[2] & half_v[15]}}, half_v}
                                       : {{24{~f3[2] & byte_v[7]}}, byte_v};
  assign be     = f3[1] ? 4'b1111 : f3[0] ? 4'b0011 << a[1:0] : 4'b0001 << a[1:0];
  assign wsh    = d << {a[1:0], 3'b000};
  always_ff @(posedge clk)
    if (!reset && commit)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
  always_ff @(posedge clk)
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      dbus_ready <= 1'b0;
      dbus_fault <= 1'b0;
      dbus_rdata <= 32'd0;
    end else begin
      dbus_ready <= enter;
      if (enter) begin
        dbus_fault <= fault;
        dbus_rdata <= (fault | op_we | hit) ? 32'd0 : load;
      end
      if (idle && req) begin
        addr_q  <= dbus_addr;
        wdata_q <= dbus_wdata;
        f3_q    <= dbus_f3;
        re_q    <= dbus_re;
        we_q    <= dbus_we;
        cnt     <= CNT_INIT;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      state <= enter ? RESP : (idle && req) ? WAIT : state == WAIT ? WAIT : IDLE;
    end
`ifdef DBUS_MMIO_EN
  always_ff @(posedge clk)
    if (reset) begin
      mmio_out    <= 32'd0;
      mmio_strobe <= 1'b0;
    end else begin
      mmio_strobe <= enter & hit & op_we & ~fault;
      if (enter & hit & op_we & ~fault) mmio_out <= d;
    end
`endif
endmodule

// File: tb/tb_dbus_ram_responder.sv
// tb_dbus_ram_responder: scoreboard bench driving one request stream into a 1-wait and a 0-wait responder.
module tb_dbus_ram_responder;
  logic clk = 0, reset = 1, re = 0, we = 0;
  logic [2:0] f3 = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] rdata1, rdata0;
  logic ready1, ready0, fault1, fault0;
`ifdef DBUS_MMIO_EN
  logic [31:0] mo1, mo0;
  logic st1, st0;
`endif
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
    logic        strobe;
    logic [31:0] mo;
  } exp_t;
  exp_t q1[$], q0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .dbus_re(re), .dbus_we(we), .dbus_addr(addr), .dbus_f3(f3),
    .dbus_wdata(wdata), .dbus_rdata(rdata1), .dbus_ready(ready1), .dbus_fault(fault1)
`ifdef DBUS_MMIO_EN
    , .mmio_out(mo1), .mmio_strobe(st1)
`endif
  );
  dbus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .dbus_re(re), .dbus_we(we), .dbus_addr(addr), .dbus_f3(f3),
    .dbus_wdata(wdata), .dbus_rdata(rdata0), .dbus_ready(ready0), .dbus_fault(fault0)
`ifdef DBUS_MMIO_EN
    , .mmio_out(mo0), .mmio_strobe(st0)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic score(input int w, input logic rdy, input logic [31:0] rd, input logic flt,
                       input logic st, input logic [31:0] mo);
    exp_t e;
    if (rdy) begin
      if ((w == 1 ? q1.size() : q0.size()) == 0) check($sformatf("spurious_ready%0d", w), 1, 0);
      else begin
        if (w == 1) e = q1.pop_front();
        else e = q0.pop_front();
        check($sformatf("rdata%0d", w), rd, e.rdata);
        check($sformatf("fault%0d", w), flt, e.fault);
        check($sformatf("latency%0d", w), cyc, e.cyc);
`ifdef DBUS_MMIO_EN
        check($sformatf("strobe%0d", w), st, e.strobe);
        if (e.strobe) check($sformatf("mmio_out%0d", w), mo, e.mo);
`endif
      end
    end
`ifdef DBUS_MMIO_EN
    else if (st) check($sformatf("stray_strobe%0d", w), st, 0);
`endif
  endtask

  always @(negedge clk) begin
`ifdef DBUS_MMIO_EN
    score(1, ready1, rdata1, fault1, st1, mo1);
    score(0, ready0, rdata0, fault0, st0, mo0);
`else
    score(1, ready1, rdata1, fault1, 1'b0, 32'd0);
    score(0, ready0, rdata0, fault0, 1'b0, 32'd0);
`endif
  end

  task automatic acc2(input logic r, input logic wr, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] e1, input logic fl1,
                      input logic [31:0] e0, input logic fl0, input logic st, input logic [31:0] mo);
    int n;
    @(negedge clk);
    re = r; we = wr; f3 = f; addr = a; wdata = d;
    q1.push_back('{e1, fl1, cyc + 2, st, mo});
    q0.push_back('{e0, fl0, cyc + 1, st, mo});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready1 && n < 20);
    re = 0; we = 0;
    if (!ready1) check("ready_timeout", ready1, 1);
  endtask

  task automatic acc(input logic r, input logic wr, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e, input logic fl);
    acc2(r, wr, f, a, d, e, fl, e, fl, 1'b0, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready1", ready1, 0);
    check("rst_fault1", fault1, 0);
    check("rst_rdata1", rdata1, 0);
    check("rst_ready0", ready0, 0);
    check("rst_rdata0", rdata0, 0);
`ifdef DBUS_MMIO_EN
    check("rst_mmio_out", mo1, 0);
    check("rst_mmio_strobe", st1, 0);
`endif
    reset = 0;
    acc(0, 1, 3'd2, 32'h0, 32'h0, 32'h0, 0);
    acc(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    acc(1, 0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    acc(0, 1, 3'd0, 32'h13, 32'hFFFFFF80, 32'h0, 0);
    acc(1, 0, 3'd0, 32'h13, 32'h0, 32'hFFFFFF80, 0);
    acc(1, 0, 3'd4, 32'h13, 32'h0, 32'h00000080, 0);
    acc(1, 0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    acc(1, 0, 3'd1, 32'h11, 32'h0, 32'h0, 1);
    acc(1, 0, 3'd2, 32'h12, 32'h0, 32'h0, 1);
    acc(0, 1, 3'd2, 32'h1000, 32'h55555555, 32'h0, 1);
    acc(1, 0, 3'd2, 32'h10000000, 32'h0, 32'h0, 1);
    acc(1, 0, 3'd2, 32'h0, 32'h0, 32'h0, 0);
    acc(1, 0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    acc(1, 1, 3'd2, 32'h10, 32'h0, 32'h0, 1);
    acc(1, 0, 3'd3, 32'h10, 32'h0, 32'h0, 1);
    acc(0, 1, 3'd3, 32'h10, 32'h0, 32'h0, 1);
    acc(0, 1, 3'd4, 32'h10, 32'h0, 32'h0, 1);
    acc(1, 0, 3'd2, 32'h10, 32'h0, 32'h80ADBEEF, 0);
    acc(0, 1, 3'd2, 32'h14, 32'h0, 32'h0, 0);
    acc(0, 1, 3'd1, 32'h16, 32'h1234CAFE, 32'h0, 0);
    acc(1, 0, 3'd2, 32'h14, 32'h0, 32'hCAFE0000, 0);
    acc(1, 0, 3'd1, 32'h16, 32'h0, 32'hFFFFCAFE, 0);
    acc(1, 0, 3'd5, 32'h16, 32'h0, 32'h0000CAFE, 0);
    acc(0, 1, 3'd0, 32'h15, 32'h0000005A, 32'h0, 0);
    acc(1, 0, 3'd2, 32'h14, 32'h0, 32'hCAFE5A00, 0);
    acc(0, 1, 3'd1, 32'h15, 32'h0000FFFF, 32'h0, 1);
    acc(1, 0, 3'd2, 32'h14, 32'h0, 32'hCAFE5A00, 0);
    acc(0, 1, 3'd2, 32'h20, 32'h11111111, 32'h0, 0);
    // the zero-wait instance completes this store before reset; the one-wait instance is caught in WAIT
    @(negedge clk);
    we = 1; f3 = 3'd2; addr = 32'h20; wdata = 32'h12345678;
    q0.push_back('{32'h0, 1'b0, cyc + 1, 1'b0, 32'h0});
    @(negedge clk);
    reset = 1; we = 0;
    @(negedge clk);
    check("abort_no_ready", ready1, 0);
    reset = 0;
    repeat (3) @(negedge clk);
    check("abort_no_ready_after", ready1, 0);
    acc2(1, 0, 3'd2, 32'h20, 32'h0, 32'h11111111, 0, 32'h12345678, 0, 1'b0, 32'h0);
`ifdef DBUS_MMIO_EN
    acc2(0, 1, 3'd2, 32'hFFFFFFF0, 32'h000000A5, 32'h0, 0, 32'h0, 0, 1'b1, 32'h000000A5);
    acc(1, 0, 3'd2, 32'hFFFFFFF0, 32'h0, 32'h0, 0);
    acc(0, 1, 3'd0, 32'hFFFFFFF0, 32'h0000005A, 32'h0, 1);
    check("mmio_out_held", mo1, 32'h000000A5);
`else
    acc(0, 1, 3'd2, 32'hFFFFFFF0, 32'h000000A5, 32'h0, 1);
`endif
    repeat (3) @(negedge clk);
    check("scoreboard_empty", q0.size() + q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
